// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and payload types for the EX->MEM pipeline register.
package ex_mem_pkg;

    localparam int unsigned IR_W    = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned EXC_W   = 5;

    localparam logic [OP_W-1:0] OP_LW  = 6'h23;
    localparam logic [OP_W-1:0] OP_LB  = 6'h20;
    localparam logic [OP_W-1:0] OP_LBU = 6'h24;
    localparam logic [OP_W-1:0] OP_LH  = 6'h21;
    localparam logic [OP_W-1:0] OP_LHU = 6'h25;
    localparam logic [OP_W-1:0] OP_SW  = 6'h2B;
    localparam logic [OP_W-1:0] OP_SB  = 6'h28;
    localparam logic [OP_W-1:0] OP_SH  = 6'h29;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    // Width-independent part of a pipeline entry; datapath fields sit beside it.
    typedef struct packed {
        logic [IR_W-1:0]    ir;
        logic [FLAGS_W-1:0] flags;
        logic [EXC_W-1:0]   excode;
    } ex_ctl_t;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM handshake bundle: upstream in_* beat and downstream out_* beat.
interface ex_mem_pipe_if #(
    parameter int unsigned DW = 32
);
    import ex_mem_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IR_W-1:0]     in_ir;
    logic [DW-1:0]       in_pc;
    logic [DW-1:0]       in_alu;
    logic [DW-1:0]       in_md;
    logic [DW-1:0]       in_rt;
    logic [FLAGS_W-1:0]  in_flags;
    logic [EXC_W-1:0]    in_excode;

    logic                out_valid;
    logic                out_ready;
    logic [IR_W-1:0]     out_ir;
    logic [DW-1:0]       out_pc;
    logic [DW-1:0]       out_pc4;
    logic [DW-1:0]       out_pc8;
    logic [DW-1:0]       out_ao;
    logic [DW-1:0]       out_md;
    logic [DW-1:0]       out_rt;
    logic [FLAGS_W-1:0]  out_flags;
    logic [EXC_W-1:0]    out_excode;

    modport master (
        output in_valid, in_ir, in_pc, in_alu, in_md, in_rt, in_flags, in_excode, out_ready,
        input  in_ready, out_valid, out_ir, out_pc, out_pc4, out_pc8, out_ao, out_md, out_rt,
               out_flags, out_excode
    );

    modport slave (
        input  in_valid, in_ir, in_pc, in_alu, in_md, in_rt, in_flags, in_excode, out_ready,
        output in_ready, out_valid, out_ir, out_pc, out_pc4, out_pc8, out_ao, out_md, out_rt,
               out_flags, out_excode
    );

endinterface

// File: rtl/ex_mem_pipe_addr_chk.sv
// Combinational exception-code generator: load/store alignment and address-window checks.
module ex_mem_addr_chk
    import ex_mem_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter logic [31:0] DMEM_TOP    = 32'h0000_2FFF,
    parameter logic [31:0] DEV0_BASE   = 32'h0000_7F00,
    parameter logic [31:0] DEV0_RLAST  = 32'h0000_7F0B,
    parameter logic [31:0] DEV0_WLAST  = 32'h0000_7F07,
    parameter logic [31:0] DEV1_BASE   = 32'h0000_7F10,
    parameter logic [31:0] DEV1_LAST   = 32'h0000_7F1B
) (
    input  logic [OP_W-1:0]  op,
    input  logic [DW-1:0]    addr,
    input  logic [EXC_W-1:0] excode_in,
    output logic [EXC_W-1:0] excode_c
);

    logic is_lw, is_lb, is_lbu, is_lh, is_lhu, is_sw, is_sb, is_sh;
    logic in_dmem, in_dev0_r, in_dev0_w, in_dev1, in_dev;
    logic adel, ades;

    assign is_lw  = (op == OP_LW);
    assign is_lb  = (op == OP_LB);
    assign is_lbu = (op == OP_LBU);
    assign is_lh  = (op == OP_LH);
    assign is_lhu = (op == OP_LHU);
    assign is_sw  = (op == OP_SW);
    assign is_sb  = (op == OP_SB);
    assign is_sh  = (op == OP_SH);

    // Unsigned window membership over the full address width.
    assign in_dmem   = (addr <= DW'(DMEM_TOP));
    assign in_dev0_r = (addr >= DW'(DEV0_BASE)) && (addr <= DW'(DEV0_RLAST));
    assign in_dev0_w = (addr >= DW'(DEV0_BASE)) && (addr <= DW'(DEV0_WLAST));
    assign in_dev1   = (addr >= DW'(DEV1_BASE)) && (addr <= DW'(DEV1_LAST));
    assign in_dev    = in_dev0_r || in_dev0_w || in_dev1;

    assign adel = (is_lw && (addr[1:0] != 2'b00))
               || ((is_lh || is_lhu) && addr[0])
               || ((is_lw || is_lb || is_lbu || is_lh || is_lhu)
                   && !(in_dmem || in_dev0_r || in_dev1))
               || ((is_lb || is_lbu || is_lh || is_lhu) && in_dev);

    assign ades = (is_sw && (addr[1:0] != 2'b00))
               || (is_sh && addr[0])
               || ((is_sw || is_sb || is_sh) && !(in_dmem || in_dev0_w || in_dev1))
               || ((is_sb || is_sh) && in_dev);

    // An upstream exception always wins over the address checks.
    always_comb begin
        excode_c = EXC_NONE;
        if (excode_in != EXC_NONE) begin
            excode_c = excode_in;
        end else if (adel) begin
            excode_c = EXC_ADEL;
        end else if (ades) begin
            excode_c = EXC_ADES;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with address-exception tagging.
// Define EX_MEM_PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter logic [31:0] DMEM_TOP    = 32'h0000_2FFF,
    parameter logic [31:0] DEV0_BASE   = 32'h0000_7F00,
    parameter logic [31:0] DEV0_RLAST  = 32'h0000_7F0B,
    parameter logic [31:0] DEV0_WLAST  = 32'h0000_7F07,
    parameter logic [31:0] DEV1_BASE   = 32'h0000_7F10,
    parameter logic [31:0] DEV1_LAST   = 32'h0000_7F1B
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    ex_mem_pipe_if.slave  bus
);

    logic [EXC_W-1:0] in_code_c;
    ex_ctl_t          in_ctl;
    logic             accept;
    logic             out_free;
    logic             load_out;

    ex_ctl_t          src_ctl;
    logic [DW-1:0]    src_pc, src_alu, src_md, src_rt;

    logic             out_valid_q;
    ex_ctl_t          out_ctl_q;
    logic [DW-1:0]    out_pc_q, out_pc4_q, out_pc8_q, out_ao_q, out_md_q, out_rt_q;

    ex_mem_addr_chk #(
        .DW(DW), .DMEM_TOP(DMEM_TOP),
        .DEV0_BASE(DEV0_BASE), .DEV0_RLAST(DEV0_RLAST), .DEV0_WLAST(DEV0_WLAST),
        .DEV1_BASE(DEV1_BASE), .DEV1_LAST(DEV1_LAST)
    ) u_addr_chk (
        .op        (bus.in_ir[31:26]),
        .addr      (bus.in_alu),
        .excode_in (bus.in_excode),
        .excode_c  (in_code_c)
    );

    assign in_ctl   = '{ir: bus.in_ir, flags: bus.in_flags, excode: in_code_c};
    assign accept   = bus.in_valid && bus.in_ready && !flush;
    assign out_free = !out_valid_q || bus.out_ready;

`ifdef EX_MEM_PIPE_SKID_EN
    logic          skid_valid_q, skid_valid_d, in_ready_q, load_skid;
    ex_ctl_t       skid_ctl_q;
    logic [DW-1:0] skid_pc_q, skid_alu_q, skid_md_q, skid_rt_q;

    assign bus.in_ready = in_ready_q;
    assign load_skid    = accept && !out_free;
    assign load_out     = out_free && (skid_valid_q || accept);
    assign skid_valid_d = load_skid || (skid_valid_q && !out_free);

    // A held skid entry is always older than anything on the input.
    assign src_ctl = skid_valid_q ? skid_ctl_q : in_ctl;
    assign src_pc  = skid_valid_q ? skid_pc_q  : bus.in_pc;
    assign src_alu = skid_valid_q ? skid_alu_q : bus.in_alu;
    assign src_md  = skid_valid_q ? skid_md_q  : bus.in_md;
    assign src_rt  = skid_valid_q ? skid_rt_q  : bus.in_rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            skid_ctl_q   <= '0;
            skid_pc_q    <= '0;
            skid_alu_q   <= '0;
            skid_md_q    <= '0;
            skid_rt_q    <= '0;
        end else if (flush) begin
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            if (load_skid) begin
                skid_ctl_q <= in_ctl;
                skid_pc_q  <= bus.in_pc;
                skid_alu_q <= bus.in_alu;
                skid_md_q  <= bus.in_md;
                skid_rt_q  <= bus.in_rt;
            end
        end
    end
`else
    assign bus.in_ready = out_free;
    assign load_out     = accept;
    assign src_ctl      = in_ctl;
    assign src_pc       = bus.in_pc;
    assign src_alu      = bus.in_alu;
    assign src_md       = bus.in_md;
    assign src_rt       = bus.in_rt;
`endif

    // Output stage; flush kills the entry but leaves the datapath fields untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ctl_q   <= '0;
            out_pc_q    <= '0;
            out_pc4_q   <= '0;
            out_pc8_q   <= '0;
            out_ao_q    <= '0;
            out_md_q    <= '0;
            out_rt_q    <= '0;
        end else if (flush) begin
            out_valid_q      <= 1'b0;
            out_ctl_q.ir     <= '0;
            out_ctl_q.excode <= '0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_ctl_q   <= src_ctl;
            out_pc_q    <= src_pc;
            out_pc4_q   <= src_pc + DW'(4);
            out_pc8_q   <= src_pc + DW'(8);
            out_ao_q    <= src_alu;
            out_md_q    <= src_md;
            out_rt_q    <= src_rt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_ir     = out_ctl_q.ir;
    assign bus.out_flags  = out_ctl_q.flags;
    assign bus.out_excode = out_ctl_q.excode;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_pc4    = out_pc4_q;
    assign bus.out_pc8    = out_pc8_q;
    assign bus.out_ao     = out_ao_q;
    assign bus.out_md     = out_md_q;
    assign bus.out_rt     = out_rt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: exception-code vector table plus stall/flush/reset sequences.
module tb_ex_mem_pipe;
    import ex_mem_pkg::*;

`ifdef EX_MEM_PIPE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;

    ex_mem_pipe_if #(.DW(32)) bus ();

    ex_mem_pipe #(.DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [4:0]  exin;
        logic [4:0]  exp;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] rt;
        logic [2:0]  flags;
        logic [4:0]  excode;
    } beat_t;

    beat_t q[$];
    beat_t cur_exp;
    beat_t a_b, b_b, c_b;
    vec_t  vt[20];
    int    n_vec = 0;
    int    n_err = 0;
    int    acc_cnt = 0;
    int    base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every downstream handshake, push on every accepted input.
    task automatic monitor();
        beat_t e;
        if (reset) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected beat: got ir %h, expected no beat", bus.out_ir);
                end else begin
                    e = q.pop_front();
                    check("beat ir",     bus.out_ir,            e.ir);
                    check("beat excode", 32'(bus.out_excode),   32'(e.excode));
                    check("beat pc",     bus.out_pc,            e.pc);
                    check("beat pc4",    bus.out_pc4,           e.pc + 32'd4);
                    check("beat pc8",    bus.out_pc8,           e.pc + 32'd8);
                    check("beat ao",     bus.out_ao,            e.alu);
                    check("beat md/rt",  bus.out_md ^ bus.out_rt, e.md ^ e.rt);
                    check("beat flags",  32'(bus.out_flags),    32'(e.flags));
                end
            end
            if (flush) begin
                q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                q.push_back(cur_exp);
                acc_cnt++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
    endtask

    function automatic beat_t mk(input logic [5:0] op, input logic [31:0] alu,
                                 input logic [4:0] exp, input int tag);
        beat_t b;
        b.ir     = {op, 26'(tag)};
        b.pc     = 32'h0040_0000 + 32'(tag) * 32'd4;
        b.alu    = alu;
        b.md     = $urandom;
        b.rt     = $urandom;
        b.flags  = 3'(tag);
        b.excode = exp;
        return b;
    endfunction

    task automatic set_in(input beat_t b, input logic [4:0] exin);
        bus.in_ir     = b.ir;
        bus.in_pc     = b.pc;
        bus.in_alu    = b.alu;
        bus.in_md     = b.md;
        bus.in_rt     = b.rt;
        bus.in_flags  = b.flags;
        bus.in_excode = exin;
        bus.in_valid  = 1'b1;
        cur_exp       = b;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        check("drain queue empty", 32'(q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"},  32'(bus.out_valid),  32'd0);
        check({tag, " out_ir"},     bus.out_ir,          32'd0);
        check({tag, " out_excode"}, 32'(bus.out_excode), 32'd0);
        check({tag, " out_flags"},  32'(bus.out_flags),  32'd0);
        check({tag, " out_pc"},     bus.out_pc,          32'd0);
        check({tag, " out_pc4"},    bus.out_pc4,         32'd0);
        check({tag, " out_pc8"},    bus.out_pc8,         32'd0);
        check({tag, " out_ao"},     bus.out_ao,          32'd0);
        check({tag, " out_md|rt"},  bus.out_md | bus.out_rt, 32'd0);
    endtask

    initial begin
        vt[0]  = '{OP_LW,  32'h0000_2FFE, 5'd0,  5'd4};
        vt[1]  = '{OP_SW,  32'h0000_2FFC, 5'd0,  5'd0};
        vt[2]  = '{OP_SW,  32'h0000_7F08, 5'd0,  5'd5};
        vt[3]  = '{OP_LW,  32'h0000_7F08, 5'd0,  5'd0};
        vt[4]  = '{OP_SB,  32'h0000_7F10, 5'd0,  5'd5};
        vt[5]  = '{OP_LW,  32'h0000_7F1C, 5'd0,  5'd4};
        vt[6]  = '{OP_LW,  32'h0000_2FFD, 5'd10, 5'd10};
        vt[7]  = '{OP_LH,  32'h0000_2FFD, 5'd0,  5'd4};
        vt[8]  = '{OP_LHU, 32'h0000_1000, 5'd0,  5'd0};
        vt[9]  = '{OP_LB,  32'h0000_3000, 5'd0,  5'd4};
        vt[10] = '{OP_LB,  32'h0000_2FFF, 5'd0,  5'd0};
        vt[11] = '{OP_SH,  32'h0000_7F04, 5'd0,  5'd5};
        vt[12] = '{OP_SW,  32'h0000_7F04, 5'd0,  5'd0};
        vt[13] = '{OP_LW,  32'h0000_7F1B, 5'd0,  5'd4};
        vt[14] = '{OP_LW,  32'h0000_7F18, 5'd0,  5'd0};
        vt[15] = '{6'h00,  32'h0000_7F1C, 5'd0,  5'd0};
        vt[16] = '{OP_SH,  32'h0000_0001, 5'd0,  5'd5};
        vt[17] = '{OP_LBU, 32'h0000_7F00, 5'd0,  5'd4};
        vt[18] = '{OP_SW,  32'hFFFF_FFFC, 5'd0,  5'd5};
        vt[19] = '{OP_LW,  32'h8000_0000, 5'd0,  5'd4};

        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ir = '0; bus.in_pc = '0; bus.in_alu = '0; bus.in_md = '0; bus.in_rt = '0;
        bus.in_flags = '0; bus.in_excode = '0;
        bus.out_ready = 1'b1;
        cur_exp = mk(6'h00, 32'd0, 5'd0, 0);

        cycle();
        cycle();
        check_zero("reset");
        reset = 1'b0;
        #1;
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        // Exception-code table, back to back with the sink always ready.
        foreach (vt[i]) begin
            set_in(mk(vt[i].op, vt[i].alu, vt[i].exp, i + 1), vt[i].exin);
            base = acc_cnt;
            for (int k = 0; k < 10 && acc_cnt == base; k++) cycle();
            check("vector accepted", 32'(acc_cnt - base), 32'd1);
        end
        bus.in_valid = 1'b0;
        drain();

        // Three-cycle downstream stall with the source still pushing.
        a_b = mk(OP_LW, 32'h0000_0040, 5'd0, 40);
        b_b = mk(OP_SW, 32'h0000_0044, 5'd0, 41);
        bus.out_ready = 1'b0;
        set_in(a_b, 5'd0);
        base = acc_cnt;
        cycle();
        set_in(b_b, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall out_ir",    bus.out_ir,         a_b.ir);
            check("stall out_pc",    bus.out_pc,         a_b.pc);
            check("stall out_ao",    bus.out_ao,         a_b.alu);
            check("stall in_ready",  32'(bus.in_ready),  32'd0);
        end
        check("stall accepted beats", 32'(acc_cnt - base), 32'(1 + SKID));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && (acc_cnt - base) < 2; k++) cycle();
        bus.in_valid = 1'b0;
        check("release accepted beats", 32'(acc_cnt - base), 32'd2);
        drain();

        // Flush coinciding with an accepting transfer.
        set_in(mk(OP_LW, 32'h0000_0100, 5'd0, 50), 5'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush out_valid",  32'(bus.out_valid),  32'd0);
        check("flush out_ir",     bus.out_ir,          32'd0);
        check("flush out_excode", 32'(bus.out_excode), 32'd0);
        check("flush in_ready",   32'(bus.in_ready),   32'd1);

        // Flush while stalled with the skid (if any) occupied.
        a_b = mk(OP_LW, 32'h0000_0200, 5'd0, 60);
        b_b = mk(OP_LW, 32'h0000_0203, 5'd4, 61);
        c_b = mk(OP_SW, 32'h0000_0208, 5'd0, 62);
        bus.out_ready = 1'b0;
        set_in(a_b, 5'd0);
        cycle();
        set_in(b_b, 5'd0);
        cycle();
        flush = 1'b1;
        set_in(c_b, 5'd0);
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("stalled flush out_valid",  32'(bus.out_valid),  32'd0);
        check("stalled flush out_ir",     bus.out_ir,          32'd0);
        check("stalled flush in_ready",   32'(bus.in_ready),   32'd1);
        cycle();
        cycle();
        check("post-flush out_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a stall.
        a_b = mk(OP_LW, 32'h0000_0300, 5'd0, 70);
        b_b = mk(OP_LW, 32'h0000_0304, 5'd0, 71);
        bus.out_ready = 1'b0;
        set_in(a_b, 5'd0);
        cycle();
        set_in(b_b, 5'd0);
        cycle();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        cycle();
        check_zero("mid-stall reset");
        reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("in_ready after mid-stall reset", 32'(bus.in_ready), 32'd1);
        cycle();
        cycle();
        check("post-reset out_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DW, default 32: datapath width of PC, ALU, MD and RT fields.
REQ-002 Parameter DMEM_TOP, default 32'h0000_2FFF: last valid data-memory byte address; the window starts at 0.
REQ-003 Parameters DEV0_BASE/DEV0_RLAST/DEV0_WLAST, default 7F00/7F0B/7F07: device-0 window, readable up to RLAST, writable up to WLAST.
REQ-004 Parameters DEV1_BASE/DEV1_LAST, default 7F10/7F1B: device-1 window, fully read/write.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 flush  in  1  synchronous kill of all held entries (exception/eret).
REQ-008 in_valid/in_ready  in/out  1/1  upstream (EX) handshake.
REQ-009 in_ir in 32, in_pc in DW, in_alu in DW, in_md in DW, in_rt in DW, in_flags in 3 ({zero,more,less}), in_excode in 5: EX payload.
REQ-010 out_valid/out_ready  out/in  1/1  downstream (MEM) handshake.
REQ-011 out_ir, out_pc, out_pc4, out_pc8, out_ao, out_md, out_rt, out_flags, out_excode: registered payload; out_pc4/out_pc8 = out_pc+4/+8.

Function
REQ-012 Transfer occurs on a cycle with in_valid && in_ready; the payload is then visible on out_* the next cycle (latency 1).
REQ-013 Without skid: in_ready = !out_valid || out_ready (combinational pass-through of ready).
REQ-014 out_* hold stable while out_valid && !out_ready.
REQ-015 Opcode decode from in_ir[31:26]: loads lw 23, lb 20, lbu 24, lh 21, lhu 25; stores sw 2B, sb 28, sh 29 (hex).
REQ-016 Load AdEL (code 4): lw with alu[1:0]!=0; lh/lhu with alu[0]!=0; address outside {DMEM, DEV0..RLAST, DEV1}; lb/lbu/lh/lhu inside any device window.
REQ-017 Store AdES (code 5): sw with alu[1:0]!=0; sh with alu[0]!=0; address outside {DMEM, DEV0..WLAST, DEV1}; sb/sh inside any device window.
REQ-018 Address comparisons are unsigned, over the full DW width.
REQ-019 Priority: a nonzero in_excode passes through unchanged; otherwise the AdEL/AdES code is used; otherwise 0.
REQ-020 The code is computed on the input and registered with its payload (no extra cycle).
REQ-021 Non-memory opcodes always yield excode 0.
REQ-022 flush clears out_valid, out_ir and out_excode to 0 at the next edge; the input is not accepted that cycle; flush overrides a simultaneous transfer.

Reset
REQ-023 On reset: out_valid=0, out_ir=0, out_excode=0, out_flags=0, all other out_* =0, skid empty.
REQ-024 in_ready=1 in the cycle after reset deasserts.
REQ-025 Reset has priority over flush and transfer; reset mid-stall drops the held entry.

Configuration
REQ-026 Macro EX_MEM_PIPE_SKID_EN defined: a one-entry skid register is added, and in_ready becomes a flop equal to "skid empty", removing the ready combinational path.
REQ-027 With skid: a beat accepted while out_valid && !out_ready goes to skid. On out_ready the skid moves to out_*. Order is preserved. Throughput is 1/cycle with no bubbles.
REQ-028 With skid: flush/reset empty both the out and skid entries.
REQ-029 Macro undefined: behaviour follows REQ-013, with no skid storage.

Structure
REQ-030 Package ex_mem_pkg holds the opcode constants, the EXC_ADEL=4/EXC_ADES=5/EXC_NONE=0 constants, and the payload struct type.
REQ-031 Sub-module ex_mem_addr_chk is the combinational excode generator (opcode, address, parameters -> code).

Verification
REQ-032 lw to alu=32'h0000_2FFE -> out_excode=4 the next cycle; sw to 32'h0000_2FFC -> 0.
REQ-033 sw to 7F08 -> 5; lw to 7F08 -> 0; sb to 7F10 -> 5; lw to 7F1C -> 4.
REQ-034 in_excode=10 with misaligned lw -> out_excode=10.
REQ-035 Hold out_ready=0 for 3 cycles with in_valid=1 -> out_* stable. Without skid, in_ready=0. With skid, exactly one extra beat is accepted. On release, beats arrive in order and none are lost.
REQ-036 flush asserted together with an accepting transfer -> next cycle out_valid=0, out_ir=0, and the skid is empty.
REQ-037 reset asserted mid-stall -> all outputs 0 the next cycle, and in_ready=1 after reset deasserts.
